// File: rtl/approx_pipe_adder.sv
// approx_pipe_adder: segmented pipelined adder with optional lower-part-OR approximation
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready    operand handshake
//   a, b, cin             operands and carry-in (cin used only in exact mode)
//   approx_en, approx_k   approximate mode enable and number of OR-ed LSBs (clamped to WIDTH)
//   out_valid, out_ready  result handshake
//   sum, cout             result and carry out of the MSB
//   approx_used           result was produced in approximate mode with K>0
//   approx_cnt            saturating count of completed approximate results
module approx_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8,
    parameter int KW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             approx_en,
    input  logic [KW-1:0]    approx_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             approx_used,
    output logic [15:0]      approx_cnt
);
    localparam int NUM_SEG = WIDTH / SEG_W;
    localparam logic [KW-1:0] K_MAX = KW'(WIDTH);

    if (WIDTH % SEG_W != 0) begin : g_chk_width
        $error("WIDTH must be a multiple of SEG_W");
    end
    if ((1 << KW) <= WIDTH) begin : g_chk_kw
        $error("KW too narrow to hold WIDTH");
    end

    // One segment of bits starting at absolute bit 'base'. Bits below k are OR-ed;
    // bit k-1 generates the carry injected at bit k, other approximate bits generate none.
    function automatic logic [SEG_W:0] seg_calc(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             c,
        input int               base,
        input logic [KW-1:0]    k
    );
        logic [SEG_W-1:0] s;
        logic cc;
        int kk;
        int n;
        s  = '0;
        cc = c;
        kk = int'(k);
        for (int i = 0; i < SEG_W; i++) begin
            n = base + i;
            if (n < kk) begin
                s[i] = x[i] | y[i];
                cc   = (n == kk - 1) ? (x[i] & y[i]) : 1'b0;
            end else begin
                s[i] = x[i] ^ y[i] ^ cc;
                cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
            end
        end
        return {cc, s};
    endfunction

    logic          adv;
    logic [KW-1:0] k_in;
    logic          c_in;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign k_in     = approx_en ? ((approx_k > K_MAX) ? K_MAX : approx_k) : '0;
    assign c_in     = (k_in == '0) & cin;

    genvar s;
    for (s = 0; s < NUM_SEG; s++) begin : stage
        localparam int LO = s * SEG_W;
        localparam int UP = WIDTH - LO;
        // operand bits still unresolved on entry to this stage
        logic [UP-1:0]       pa, pb;
        logic                pc, pv;
        logic [KW-1:0]       pk;
        logic [SEG_W:0]      r;
        logic [LO+SEG_W-1:0] ns, rs;
        logic                rc, rv;
        logic [KW-1:0]       rk;
        if (s == 0) begin : g_src
            assign pa = a;
            assign pb = b;
            assign pc = c_in;
            assign pv = in_valid;
            assign pk = k_in;
            assign ns = r[SEG_W-1:0];
        end else begin : g_src
            assign pa = stage[s-1].g_op.ra;
            assign pb = stage[s-1].g_op.rb;
            assign pc = stage[s-1].rc;
            assign pv = stage[s-1].rv;
            assign pk = stage[s-1].rk;
            assign ns = {r[SEG_W-1:0], stage[s-1].rs};
        end
        assign r = seg_calc(pa[SEG_W-1:0], pb[SEG_W-1:0], pc, LO, pk);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv <= 1'b0;
                rc <= 1'b0;
                rs <= '0;
                rk <= '0;
            end else if (adv) begin
                rv <= pv;
                rc <= r[SEG_W];
                rs <= ns;
                rk <= pk;
            end
        end
        if (s < NUM_SEG - 1) begin : g_op
            logic [UP-SEG_W-1:0] ra, rb;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra <= '0;
                    rb <= '0;
                end else if (adv) begin
                    ra <= pa[UP-1:SEG_W];
                    rb <= pb[UP-1:SEG_W];
                end
            end
        end
    end

    assign out_valid   = stage[NUM_SEG-1].rv;
    assign sum         = stage[NUM_SEG-1].rs;
    assign cout        = stage[NUM_SEG-1].rc;
    assign approx_used = stage[NUM_SEG-1].rv & (|stage[NUM_SEG-1].rk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            approx_cnt <= '0;
        else if (out_valid & out_ready & approx_used & (approx_cnt != 16'hFFFF))
            approx_cnt <= approx_cnt + 16'd1;
    end
endmodule

// File: tb/tb_approx_pipe_adder.sv
// tb_approx_pipe_adder: scoreboard bench for approx_pipe_adder (WIDTH=32, SEG_W=8)
module tb_approx_pipe_adder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0, approx_en = 1'b0;
    logic [5:0]  approx_k = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout, approx_used;
    logic [15:0] approx_cnt;

    approx_pipe_adder #(.WIDTH(32), .SEG_W(8), .KW(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .approx_en(approx_en), .approx_k(approx_k),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .approx_used(approx_used), .approx_cnt(approx_cnt)
    );

    always #5 clk = ~clk;

    logic [33:0] q[$];
    int compared = 0, mismatched = 0, exp_cnt = 0;
    logic [33:0] held;
    logic stalled = 1'b0;
    logic rnd_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {approx_used, cout, sum} reference, built from masked wide additions
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic e, input logic [5:0] k);
        int kk;
        logic [32:0] m, hi;
        logic [31:0] lo;
        logic cy;
        kk = e ? ((k > 6'd32) ? 32 : int'(k)) : 0;
        if (kk == 0) begin
            hi = {1'b0, x} + {1'b0, y} + 33'(c);
            return {1'b0, hi};
        end
        m  = (33'd1 << kk) - 33'd1;
        lo = (x | y) & m[31:0];
        cy = x[kk-1] & y[kk-1];
        hi = {1'b0, x & ~m[31:0]} + {1'b0, y & ~m[31:0]} + (33'(cy) << kk);
        return {1'b1, hi[32], hi[31:0] | lo};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled)
                check("hold", {out_valid, approx_used, cout, sum}, {1'b1, held});
            if (out_valid && !out_ready) begin
                check("in_ready_stall", 64'(in_ready), 64'd0);
                held = {approx_used, cout, sum};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: got %h expected none", {approx_used, cout, sum});
                end else begin
                    logic [33:0] e;
                    e = q.pop_front();
                    check("result", {approx_used, cout, sum}, 64'(e));
                    if (e[33]) exp_cnt++;
                end
            end
        end
    end

    // called at posedge+#1; returns at posedge+#1 after the accepting edge
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input logic te, input logic [5:0] tk, input logic [33:0] exp);
        bit ok;
        a = ta; b = tb_v; cin = tc; approx_en = te; approx_k = tk; in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) q.push_back(exp);
        else check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && q.size() > 0; n++) @(negedge clk);
        check("drain_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_approx_cnt", 64'(approx_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 6'd0, {1'b0, 1'b1, 32'h00000000});
        for (lat = 1; lat < 20; lat++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", 64'(lat), 64'd4);
        drain();

        send(32'h00000080, 32'h00000080, 1'b0, 1'b1, 6'd8,  {1'b1, 1'b0, 32'h00000180});
        send(32'h000000FF, 32'h00000001, 1'b0, 1'b1, 6'd8,  {1'b1, 1'b0, 32'h000000FF});
        send(32'h80000001, 32'h80000003, 1'b0, 1'b1, 6'd40, {1'b1, 1'b1, 32'h80000003});
        send(32'h00000005, 32'h00000007, 1'b1, 1'b1, 6'd0,  {1'b0, 1'b0, 32'h0000000D});
        send(32'h00000030, 32'h00000010, 1'b1, 1'b1, 6'd5,  {1'b1, 1'b0, 32'h00000050});
        send(32'h00000F00, 32'h00000800, 1'b0, 1'b1, 6'd12, {1'b1, 1'b0, 32'h00001F00});
        send(32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 6'd0,  {1'b0, 1'b0, 32'h01000000});
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 6'd20, {1'b0, 1'b1, 32'h00000000});
        drain();
        check("approx_cnt_directed", 64'(approx_cnt), 64'd5);

        fork
            begin
                send(32'h00000001, 32'h00000002, 1'b0, 1'b0, 6'd0, {1'b0, 1'b0, 32'h00000003});
                send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 6'd0, {1'b0, 1'b0, 32'h00000100});
                send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 6'd0, {1'b0, 1'b0, 32'h00010000});
                send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 6'd0, {1'b0, 1'b0, 32'h80000000});
                send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 6'd0, {1'b0, 1'b1, 32'hFFFFFFFE});
                send(32'h12345678, 32'h11111111, 1'b0, 1'b0, 6'd0, {1'b0, 1'b0, 32'h23456789});
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h00000011, 32'h00000022, 1'b0, 1'b1, 6'd4, {1'b1, 1'b0, 32'h00000033});
        send(32'h00000001, 32'h00000001, 1'b0, 1'b0, 6'd0, {1'b0, 1'b0, 32'h00000002});
        send(32'h00000003, 32'h00000004, 1'b0, 1'b0, 6'd0, {1'b0, 1'b0, 32'h00000007});
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_approx_cnt", 64'(approx_cnt), 64'd0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    logic [31:0] ra, rb;
                    logic rc, re;
                    logic [5:0] rk;
                    ra = $urandom;
                    rb = $urandom;
                    rc = 1'($urandom % 2);
                    re = 1'($urandom % 2);
                    rk = 6'($urandom_range(0, 63));
                    send(ra, rb, rc, re, rk, model(ra, rb, rc, re, rk));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom % 4) != 0;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("approx_cnt_random", 64'(approx_cnt), 64'(exp_cnt));

        force dut.approx_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.approx_cnt;
        @(posedge clk);
        #1;
        send(32'h00000080, 32'h00000080, 1'b0, 1'b1, 6'd8, {1'b1, 1'b0, 32'h00000180});
        drain();
        check("approx_cnt_saturate", 64'(approx_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
